// File: rtl/adc_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_sampler_if
// Description : Bundles the ADC-side and output-side signals of adc_sampler.
//               The sampler connects through the slave modport and its
//               environment (ADC model, downstream bridge) through master.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_sampler_if;
  logic        enable_i;        // run request
  logic        adc_clk_o;       // ADC conversion clock
  logic [13:0] adc_data_i;      // ADC parallel output, offset binary
  logic        adc_otr_i;       // ADC out-of-range flag
  logic [13:0] adc_data_o;      // averaged sample
  logic        adc_data_rdy_o;  // held ready strobe
  logic        overrange_o;     // block contained an out-of-range sample

  modport slave (
    input  enable_i,
    input  adc_data_i,
    input  adc_otr_i,
    output adc_clk_o,
    output adc_data_o,
    output adc_data_rdy_o,
    output overrange_o
  );

  modport master (
    output enable_i,
    output adc_data_i,
    output adc_otr_i,
    input  adc_clk_o,
    input  adc_data_o,
    input  adc_data_rdy_o,
    input  overrange_o
  );
endinterface
`default_nettype wire

// File: rtl/adc_sampler.sv
`default_nettype none
// ============================================================================
// Module      : adc_sampler
// Description : ADC front end. Divides the system clock down to the ADC
//               conversion clock, discards the ADC pipeline-latency samples
//               after every start, averages blocks of 2^DEC_LOG2 captures and
//               presents each result with a held ready strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sampler #(
  parameter int unsigned CLK_DIV  = 12,  // system clocks per conversion clock
  parameter int unsigned DEC_LOG2 = 2,   // log2 of samples per output word
  parameter int unsigned PIPE_LAT = 3,   // captures discarded after start
  parameter int unsigned RDY_HOLD = 4    // cycles the ready strobe stays high
) (
  input  logic          clk_i,
  input  logic          reset_i,
  adc_sampler_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned FCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned SCNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam int unsigned ACC_W  = 14 + DEC_LOG2;
  localparam int unsigned HOLD_W = $clog2(RDY_HOLD + 1);
  localparam int unsigned NSAMP  = 1 << DEC_LOG2;

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,   state_d;
  logic [DIV_W-1:0]  div_q,     div_d;
  logic              adc_clk_q, adc_clk_d;
  logic [FCNT_W-1:0] fcnt_q,    fcnt_d;
  logic [SCNT_W-1:0] scnt_q,    scnt_d;
  logic [ACC_W-1:0]  acc_q,     acc_d;
  logic              otr_acc_q, otr_acc_d;
  logic [13:0]       data_q,    data_d;
  logic              ovr_q,     ovr_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              w_capture;    // last low-phase cycle of the ADC clock
  logic              w_active;     // converter running and still enabled
  logic              w_scnt_last;  // this capture completes a block
  logic [ACC_W-1:0]  w_sum;        // running sum including the current sample
  logic [13:0]       w_avg;        // block average, truncated

  assign w_capture   = (div_q == DIV_W'(CLK_DIV - 1));
  assign w_active    = (state_q != S_IDLE) && bus.enable_i;
  assign w_scnt_last = (scnt_q == SCNT_W'(NSAMP - 1));
  // The accumulator is wide enough for 2^DEC_LOG2 full-scale samples, so the
  // sum never wraps and the shifted result always fits in 14 bits.
  assign w_sum       = acc_q + ACC_W'(bus.adc_data_i);
  assign w_avg       = 14'(w_sum >> DEC_LOG2);

  // Sequencer: IDLE -> FLUSH (pipeline latency) -> RUN; any drop of enable
  // returns to IDLE so that a restart always re-flushes the ADC pipeline.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        fcnt_d = '0;
        if (bus.enable_i) begin
          state_d = (PIPE_LAT == 0) ? S_RUN : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!bus.enable_i) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end else if (w_capture) begin
          if (fcnt_q == FCNT_W'(PIPE_LAT - 1)) begin
            state_d = S_RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!bus.enable_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Conversion clock divider: counts 0..CLK_DIV-1 while active, high during
  // the first half of the period. The clock flop follows the next count so
  // the first rising edge appears in the first cycle after leaving IDLE.
  always_comb begin
    div_d = '0;
    if (w_active) begin
      div_d = w_capture ? '0 : div_q + 1'b1;
    end
    adc_clk_d = (state_d != S_IDLE) && (div_d < DIV_W'(CLK_DIV / 2));
  end

  // Block averaging and output update on each RUN capture; a stop clears the
  // partial block but leaves the last published word and overrange flag.
  always_comb begin
    scnt_d    = scnt_q;
    acc_d     = acc_q;
    otr_acc_d = otr_acc_q;
    data_d    = data_q;
    ovr_d     = ovr_q;
    if (!w_active) begin
      scnt_d    = '0;
      acc_d     = '0;
      otr_acc_d = 1'b0;
    end else if (w_capture && (state_q == S_RUN)) begin
      if (w_scnt_last) begin
        scnt_d    = '0;
        acc_d     = '0;
        otr_acc_d = 1'b0;
        data_d    = w_avg;
        ovr_d     = otr_acc_q | bus.adc_otr_i;
      end else begin
        scnt_d    = scnt_q + 1'b1;
        acc_d     = w_sum;
        otr_acc_d = otr_acc_q | bus.adc_otr_i;
      end
    end
  end

  // Ready strobe length: reload on a new word, count down otherwise, and
  // cancel immediately when the converter stops.
  always_comb begin
    hold_d = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
    if (!w_active) begin
      hold_d = '0;
    end else if (w_capture && (state_q == S_RUN) && w_scnt_last) begin
      hold_d = HOLD_W'(RDY_HOLD);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      adc_clk_q <= 1'b0;
      fcnt_q    <= '0;
      scnt_q    <= '0;
      acc_q     <= '0;
      otr_acc_q <= 1'b0;
      data_q    <= '0;
      ovr_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      adc_clk_q <= adc_clk_d;
      fcnt_q    <= fcnt_d;
      scnt_q    <= scnt_d;
      acc_q     <= acc_d;
      otr_acc_q <= otr_acc_d;
      data_q    <= data_d;
      ovr_q     <= ovr_d;
      hold_q    <= hold_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all straight from flops
  // --------------------------------------------------------------------------
  assign bus.adc_clk_o      = adc_clk_q;
  assign bus.adc_data_o     = data_q;
  assign bus.overrange_o    = ovr_q;
  assign bus.adc_data_rdy_o = (hold_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_adc_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_sampler
// Description : Self-checking bench for adc_sampler. A cycle-level reference
//               derives every output from the elapsed time since start-up and
//               the captured sample values; literal checks pin key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sampler;
  localparam int CLK_DIV  = 12;
  localparam int DEC_LOG2 = 2;
  localparam int PIPE_LAT = 3;
  localparam int RDY_HOLD = 4;
  localparam int NS       = 1 << DEC_LOG2;
  localparam int PERIOD   = CLK_DIV * NS;
  localparam int FIRST    = (PIPE_LAT + NS) * CLK_DIV;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  adc_sampler_if bus ();

  adc_sampler #(
    .CLK_DIV (CLK_DIV),
    .DEC_LOG2(DEC_LOG2),
    .PIPE_LAT(PIPE_LAT),
    .RDY_HOLD(RDY_HOLD)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference state: k is the number of cycles since leaving IDLE.
  bit          running  = 1'b0;
  int          k        = 0;
  int          m_sum    = 0;
  int          m_n      = 0;
  bit          m_otr    = 1'b0;
  int          rdy_left = 0;
  logic [13:0] exp_data = '0;
  logic        exp_ovr  = 1'b0;
  logic        exp_clk  = 1'b0;
  logic        exp_rdy  = 1'b0;

  // Capture values queued for the upcoming RUN captures.
  int cap_v[$];
  bit cap_o[$];

  task automatic push(input int v, input bit o);
    cap_v.push_back(v);
    cap_o.push_back(o);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_k(input int n);
    int budget;
    budget = 4000;
    while (!(running && k == n) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      tests++;
      fails++;
      $display("FAIL wait_k: cycle %0d never reached, got timeout, expected reach", n);
    end
  endtask

  // Reference model, evaluated on every rising edge with the inputs of the
  // cycle that just ended.
  initial begin
    bit loaded;
    forever begin
      @(posedge clk);
      if (reset_i) begin
        running = 0; k = 0; m_sum = 0; m_n = 0; m_otr = 0;
        rdy_left = 0; exp_data = '0; exp_ovr = 1'b0;
      end else if (!running) begin
        if (rdy_left > 0) rdy_left--;
        if (bus.enable_i) begin
          running = 1; k = 0;
        end
      end else if (!bus.enable_i) begin
        running = 0; k = 0; m_sum = 0; m_n = 0; m_otr = 0; rdy_left = 0;
      end else begin
        loaded = 0;
        if ((k % CLK_DIV) == CLK_DIV - 1 && (k / CLK_DIV) >= PIPE_LAT) begin
          m_sum += int'(bus.adc_data_i);
          m_otr |= bus.adc_otr_i;
          m_n++;
          if (m_n == NS) begin
            exp_data = 14'(m_sum / NS);
            exp_ovr  = m_otr;
            m_sum = 0; m_n = 0; m_otr = 0;
            rdy_left = RDY_HOLD;
            loaded = 1;
          end
        end
        if (!loaded && rdy_left > 0) rdy_left--;
        k++;
      end
      exp_clk = running && ((k % CLK_DIV) < CLK_DIV / 2);
      exp_rdy = (rdy_left > 0);
    end
  end

  // ADC model: queued values on RUN captures, random data everywhere else so
  // that a capture at the wrong cycle is visible.
  initial begin
    bus.adc_data_i = '0;
    bus.adc_otr_i  = 1'b0;
    forever begin
      @(negedge clk);
      if (running && (k % CLK_DIV) == CLK_DIV - 1 && (k / CLK_DIV) >= PIPE_LAT
          && cap_v.size() > 0) begin
        bus.adc_data_i = 14'(cap_v.pop_front());
        bus.adc_otr_i  = cap_o.pop_front();
      end else begin
        bus.adc_data_i = 14'($urandom_range(0, 16383));
        bus.adc_otr_i  = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Cycle-by-cycle comparison against the reference.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        tests++;
        if (bus.adc_clk_o !== exp_clk || bus.adc_data_o !== exp_data ||
            bus.adc_data_rdy_o !== exp_rdy || bus.overrange_o !== exp_ovr) begin
          fails++;
          $display("FAIL cycle_compare k=%0d: got clk=%b data=%0d rdy=%b ovr=%b, expected clk=%b data=%0d rdy=%b ovr=%b",
                   k, bus.adc_clk_o, bus.adc_data_o, bus.adc_data_rdy_o, bus.overrange_o,
                   exp_clk, exp_data, exp_rdy, exp_ovr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // Directed sequence with hand-computed literal checks.
  initial begin
    logic [13:0] saved;
    reset_i      = 1'b1;
    bus.enable_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_clk",  bus.adc_clk_o, 0);
    chk("reset_data", bus.adc_data_o, 0);
    chk("reset_rdy",  bus.adc_data_rdy_o, 0);
    chk("reset_ovr",  bus.overrange_o, 0);

    push(100, 0); push(101, 0); push(102, 0); push(103, 0);
    push(16383, 0); push(16383, 1); push(16383, 0); push(16383, 0);
    push(0, 0); push(0, 0); push(0, 0); push(3, 0);
    push(1, 0); push(1, 0); push(1, 0); push(2, 0);
    reset_i = 1'b0;
    @(negedge clk);
    bus.enable_i = 1'b1;

    // Clock shape and flush
    wait_k(0);  chk("clk_first_rise", bus.adc_clk_o, 1);
    wait_k(5);  chk("clk_high_end",   bus.adc_clk_o, 1);
    wait_k(6);  chk("clk_fall",       bus.adc_clk_o, 0);
    wait_k(11); chk("clk_low_end",    bus.adc_clk_o, 0);
    wait_k(12); chk("clk_second_rise", bus.adc_clk_o, 1);
    chk("flush_rdy_1", bus.adc_data_rdy_o, 0);
    wait_k(24); chk("flush_rdy_2", bus.adc_data_rdy_o, 0);
    wait_k(36); chk("flush_rdy_3", bus.adc_data_rdy_o, 0);

    // Averaging 100..103
    wait_k(FIRST - 1); chk("avg_rdy_before", bus.adc_data_rdy_o, 0);
    wait_k(FIRST);
    chk("avg_data", bus.adc_data_o, 101);
    chk("avg_ovr",  bus.overrange_o, 0);
    chk("avg_rdy",  bus.adc_data_rdy_o, 1);
    wait_k(FIRST + RDY_HOLD - 1); chk("avg_rdy_last", bus.adc_data_rdy_o, 1);
    wait_k(FIRST + RDY_HOLD);     chk("avg_rdy_drop", bus.adc_data_rdy_o, 0);

    // Full scale with overrange, then clean truncation blocks
    wait_k(FIRST + PERIOD - 1); chk("fs_rdy_before", bus.adc_data_rdy_o, 0);
    wait_k(FIRST + PERIOD);
    chk("fs_rdy",  bus.adc_data_rdy_o, 1);
    chk("fs_data", bus.adc_data_o, 16383);
    chk("fs_ovr",  bus.overrange_o, 1);
    wait_k(FIRST + 2 * PERIOD);
    chk("trunc0_data", bus.adc_data_o, 0);
    chk("trunc0_ovr",  bus.overrange_o, 0);
    wait_k(FIRST + 3 * PERIOD);
    chk("trunc1_data", bus.adc_data_o, 1);

    // Random blocks, then disable two cycles into a strobe
    wait_k(FIRST + 8 * PERIOD);
    saved = exp_data;
    wait_k(FIRST + 8 * PERIOD + 1);
    bus.enable_i = 1'b0;
    @(negedge clk);
    chk("dis_rdy",  bus.adc_data_rdy_o, 0);
    chk("dis_clk",  bus.adc_clk_o, 0);
    chk("dis_data", bus.adc_data_o, saved);
    repeat (5) @(negedge clk);
    bus.enable_i = 1'b1;
    wait_k(0);         chk("reen_clk",    bus.adc_clk_o, 1);
    wait_k(47);        chk("reen_flush",  bus.adc_data_rdy_o, 0);
    wait_k(FIRST - 1); chk("reen_before", bus.adc_data_rdy_o, 0);
    wait_k(FIRST);     chk("reen_first",  bus.adc_data_rdy_o, 1);

    // Reset with two samples accumulated
    wait_k(FIRST + 6);
    bus.enable_i = 1'b0;
    @(negedge clk);
    push(16000, 1); push(16000, 1);
    bus.enable_i = 1'b1;
    wait_k(61);
    reset_i = 1'b1;
    @(negedge clk);
    chk("rst_clk",  bus.adc_clk_o, 0);
    chk("rst_data", bus.adc_data_o, 0);
    chk("rst_rdy",  bus.adc_data_rdy_o, 0);
    chk("rst_ovr",  bus.overrange_o, 0);
    reset_i = 1'b0;
    push(4, 0); push(8, 0); push(12, 0); push(16, 0);
    wait_k(FIRST);
    chk("post_rst_data", bus.adc_data_o, 10);
    chk("post_rst_ovr",  bus.overrange_o, 0);
    chk("post_rst_rdy",  bus.adc_data_rdy_o, 1);
    wait_k(FIRST + 2 * PERIOD + 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/adc_sampler.md
# adc_sampler

Front end of the audio path. Generates the conversion clock for the parallel 14-bit pipelined ADC and discards the ADC's pipeline-latency samples after start-up. It averages blocks of 2^DEC_LOG2 samples and presents each result as a 14-bit word with a held ready strobe. The downstream PC/FIFO bridge edge-detects this strobe to start each two-byte USB transmission.

## Interface
- CLK_DIV, 12: system clocks per ADC conversion clock period; even, ≥ 4.
- DEC_LOG2, 2: log2 of the number of samples averaged per output word; 0..4.
- PIPE_LAT, 3: ADC pipeline latency in conversions; captures discarded after each start.
- RDY_HOLD, 4: cycles adc_data_rdy_o stays high per output; 1 ≤ RDY_HOLD < CLK_DIV·2^DEC_LOG2.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  run request; low stops the converter clock.
- adc_clk_o  out  1  ADC conversion clock.
- adc_data_i  in  14  ADC parallel output, unsigned offset binary.
- adc_otr_i  in  1  ADC out-of-range flag, aligned with adc_data_i.
- adc_data_o  out  14  averaged sample.
- adc_data_rdy_o  out  1  high for RDY_HOLD cycles when adc_data_o updates.
- overrange_o  out  1  valid with adc_data_o: some sample in the block had otr set.

## Operation
- **Reset values:** adc_clk_o=0, adc_data_o=0, adc_data_rdy_o=0, overrange_o=0, state IDLE, all counters and the accumulator 0.
- **IDLE**
  - Divider counter held at 0, adc_clk_o=0.
  - enable_i=1 → FLUSH.
- **Divider (FLUSH/RUN)**
  - div counts 0..CLK_DIV-1, wrapping.
  - adc_clk_o = (div < CLK_DIV/2), registered.
- **Capture point:** the cycle with div == CLK_DIV-1, i.e. the last low-phase cycle.
- **FLUSH**
  - Counts captures.
  - After PIPE_LAT captures, go to RUN; the first RUN capture is the next one.
  - Flushed data is ignored entirely.
- **RUN**
  - Each capture adds adc_data_i to acc (14+DEC_LOG2 bits, zero-extended) and ORs adc_otr_i into otr_acc.
  - Sample counter scnt runs 0..2^DEC_LOG2-1.
  - On the capture where scnt wraps to 0, including that sample:
    - adc_data_o ← (acc + adc_data_i) >> DEC_LOG2, truncated.
    - overrange_o ← otr_acc | adc_otr_i.
    - acc and otr_acc clear.
    - rdy hold counter loads RDY_HOLD.
  - DEC_LOG2=0 means pass-through: every capture produces an output.
- **Ready strobe**
  - adc_data_rdy_o = (hold counter ≠ 0); the counter decrements each cycle.
  - adc_data_o and overrange_o stay stable until the next output.
- **enable_i low in FLUSH/RUN**
  - Next cycle: state IDLE, adc_clk_o=0, div/scnt/acc/otr_acc cleared, hold counter cleared so adc_data_rdy_o drops.
  - adc_data_o and overrange_o keep their last values.
  - Re-enable always performs a full FLUSH.
- **enable_i and reset_i both active:** reset wins.
- **Sum width:** the sum of 2^DEC_LOG2 samples of 16383 fits in acc. No saturation is needed; the output maximum is 16383.

## Timing
- Output period is CLK_DIV·2^DEC_LOG2 cycles; 48 with defaults (250 kS/s output at 12 MHz).
- First adc_clk_o rising edge is 1 cycle after the cycle in which enable_i is sampled high in IDLE.
- A capture at cycle t puts its output on adc_data_o and raises adc_data_rdy_o at t+1 (one register stage).
- First output after enable, defaults: (PIPE_LAT + 2^DEC_LOG2)·CLK_DIV = 84 cycles after leaving IDLE.
- adc_data_rdy_o is low for at least one cycle between strobes, guaranteed by the RDY_HOLD bound. Each strobe is therefore a clean rising edge for the downstream edge detector.
- No output back-pressure; the consumer must finish within one output period.

## Test plan
- **Clock shape:** reset, then enable=1.
  - adc_clk_o period 12 cycles, 6 high / 6 low.
  - First rise 1 cycle after leaving IDLE; adc_data_rdy_o stays 0 during the 3 flush captures.
- **Averaging:** after flush, drive successive captures 100, 101, 102, 103.
  - adc_data_o=101, overrange_o=0, adc_data_rdy_o high exactly 4 cycles starting one cycle after the 4th capture.
  - Next block strobe arrives 48 cycles later.
- **Full scale and overrange:** all captures 16383 with adc_otr_i=1 on the 2nd sample only.
  - adc_data_o=16383 and overrange_o=1 for that block.
  - Next clean block gives overrange_o=0.
- **Truncation:** captures 0, 0, 0, 3 → adc_data_o=0. Captures 1, 1, 1, 2 → adc_data_o=1.
- **Mid-run disable:** drop enable_i two cycles into a rdy strobe.
  - Next cycle: adc_data_rdy_o=0, adc_clk_o=0, adc_data_o unchanged.
  - Re-enable: 3 captures flushed, first new output 84 cycles after leaving IDLE.
- **Reset mid-block:** assert reset_i with 2 samples accumulated.
  - All outputs 0 next cycle.
  - After release and enable, the partial sum does not leak into the first output.
